// File: rtl/avl_body_fetch_if.sv
// Handshake and bus bundle for avl_body_fetch: control, Avalon-MM read master, body record stream.
// The master modport is the fetch engine's view; slave is the environment's view.
interface avl_body_fetch_if;
  logic        START;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic        AVL_READ;
  logic [7:0]  AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic        AVL_WAITREQUEST;
  logic        AVL_READDATAVALID;
  logic [31:0] AVL_READDATA;
  logic        BODY_VALID;
  logic        BODY_READY;
  logic [3:0]  BODY_ID;
  logic [31:0] BODY_RAD;
  logic [31:0] BODY_X;
  logic [31:0] BODY_Y;
  logic [31:0] BODY_Z;

  modport master (
    input  START, AVL_WAITREQUEST, AVL_READDATAVALID, AVL_READDATA, BODY_READY,
    output BUSY, DONE, ERROR, AVL_READ, AVL_ADDR, AVL_BYTE_EN,
           BODY_VALID, BODY_ID, BODY_RAD, BODY_X, BODY_Y, BODY_Z
  );

  modport slave (
    output START, AVL_WAITREQUEST, AVL_READDATAVALID, AVL_READDATA, BODY_READY,
    input  BUSY, DONE, ERROR, AVL_READ, AVL_ADDR, AVL_BYTE_EN,
           BODY_VALID, BODY_ID, BODY_RAD, BODY_X, BODY_Y, BODY_Z
  );
endinterface

// File: rtl/avl_body_fetch.sv
// Fetches a body count and then radius/x/y/z per body over Avalon-MM, emitting one record per body.
// Optional bus stall timeout: define AVL_BODY_FETCH_TIMEOUT_EN.
module avl_body_fetch #(
  parameter int MAX_BODIES     = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             CLK,
  input  logic             RESET,
  avl_body_fetch_if.master bus,
  output logic [2:0]       dbg_state
);
  // Record stream: BODY_VALID holds with stable BODY_* until the cycle BODY_READY=1; a read is
  // accepted on the first AVL_READ cycle with AVL_WAITREQUEST=0, with one read outstanding.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    NUM_REQ  = 3'd1,
    NUM_WAIT = 3'd2,
    FLD_REQ  = 3'd3,
    FLD_WAIT = 3'd4,
    EMIT     = 3'd5,
    FIN      = 3'd6
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BODIES);

  state_t      state, next_state;
  logic [7:0]  count;
  logic [3:0]  idx;
  logic [1:0]  fld;
  logic [7:0]  addr;
  logic [31:0] rad, pos_x, pos_y, pos_z;
  logic [7:0]  num_clamped;
  logic        tmo_hit;
  logic        error;

  // Field f of body i lives at 13 + i + 10*f.
  function automatic logic [7:0] field_addr(input logic [3:0] i, input logic [1:0] f);
    return 8'd13 + {4'd0, i} + ({6'd0, f} * 8'd10);
  endfunction

  assign num_clamped = (bus.AVL_READDATA[7:0] > MAX_CNT) ? MAX_CNT : bus.AVL_READDATA[7:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.START) next_state = NUM_REQ;
      NUM_REQ:  if (!bus.AVL_WAITREQUEST) next_state = NUM_WAIT;
      NUM_WAIT: if (bus.AVL_READDATAVALID) next_state = (num_clamped == 8'd0) ? FIN : FLD_REQ;
      FLD_REQ:  if (!bus.AVL_WAITREQUEST) next_state = FLD_WAIT;
      FLD_WAIT: if (bus.AVL_READDATAVALID) next_state = (fld == 2'd3) ? EMIT : FLD_REQ;
      EMIT:     if (bus.BODY_READY) next_state = ({4'd0, idx} == count) ? FIN : FLD_REQ;
      FIN:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (tmo_hit) next_state = FIN;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
      idx   <= '0;
      fld   <= '0;
      addr  <= '0;
      rad   <= '0;
      pos_x <= '0;
      pos_y <= '0;
      pos_z <= '0;
    end else begin
      case (state)
        IDLE: if (bus.START) begin
          addr  <= 8'd1;
          count <= '0;
          idx   <= '0;
          fld   <= '0;
        end
        NUM_WAIT: if (bus.AVL_READDATAVALID && !tmo_hit) begin
          count <= num_clamped;
          idx   <= 4'd1;
          fld   <= 2'd0;
          addr  <= field_addr(4'd1, 2'd0);
        end
        FLD_WAIT: if (bus.AVL_READDATAVALID && !tmo_hit) begin
          case (fld)
            2'd0:    rad   <= bus.AVL_READDATA;
            2'd1:    pos_x <= bus.AVL_READDATA;
            2'd2:    pos_y <= bus.AVL_READDATA;
            default: pos_z <= bus.AVL_READDATA;
          endcase
          if (fld != 2'd3) begin
            fld  <= fld + 2'd1;
            addr <= field_addr(idx, fld + 2'd1);
          end
        end
        EMIT: if (bus.BODY_READY && ({4'd0, idx} != count)) begin
          idx  <= idx + 4'd1;
          fld  <= 2'd0;
          addr <= field_addr(idx + 4'd1, 2'd0);
        end
        default: ;
      endcase
    end
  end

`ifdef AVL_BODY_FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] stall_cnt;
  logic       in_bus_phase;
  logic       req_entry;

  assign in_bus_phase = (state == NUM_REQ) || (state == NUM_WAIT) ||
                        (state == FLD_REQ) || (state == FLD_WAIT);
  // Each request/response pair gets a fresh stall budget.
  assign req_entry    = ((next_state == NUM_REQ) || (next_state == FLD_REQ)) && (next_state != state);
  assign tmo_hit      = in_bus_phase && (stall_cnt == TMO_LIMIT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt <= '0;
      error     <= 1'b0;
    end else begin
      if (state == IDLE && bus.START) error <= 1'b0;
      else if (tmo_hit)               error <= 1'b1;
      if (req_entry)         stall_cnt <= '0;
      else if (in_bus_phase) stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign tmo_hit        = 1'b0;
  assign error          = 1'b0;
`endif

  assign bus.AVL_READ    = ((state == NUM_REQ) || (state == FLD_REQ)) && !tmo_hit;
  assign bus.AVL_ADDR    = addr;
  assign bus.AVL_BYTE_EN = 4'b1111;
  assign bus.BUSY        = (state != IDLE) && (state != FIN);
  assign bus.DONE        = (state == FIN);
  assign bus.ERROR       = error;
  assign bus.BODY_VALID  = (state == EMIT);
  assign bus.BODY_ID     = idx;
  assign bus.BODY_RAD    = rad;
  assign bus.BODY_X      = pos_x;
  assign bus.BODY_Y      = pos_y;
  assign bus.BODY_Z      = pos_z;
  assign dbg_state       = state;
endmodule
